// File: rtl/pwm_cfg_sequencer.sv
// rtl/pwm_cfg_sequencer.sv - bus master that programs NCH PWM channel banks (duty, period, enable)
//
// Optional feature macro: PWM_CFG_READBACK_EN (adds a READ phase after every write and
// drives the sticky err flag on readback mismatch).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle request to begin a sequence (ignored unless idle)
//   cfg_enable  per-channel enable bits
//   cfg_period  packed per-channel periods, channel i at [i*DATA_W +: DATA_W]
//   cfg_duty    packed per-channel duties, same packing
//   rd_data     bus read data (readback build only)
//   adr, d_in   bus address / write data
//   cs, wr, rd  bus chip select / write strobe / read strobe
//   busy        sequence in progress
//   done        one-cycle pulse after the final access
//   err         sticky readback mismatch flag
module pwm_cfg_sequencer #(
   parameter int              NCH       = 2,
   parameter int              DATA_W    = 32,
   parameter int              ADDR_W    = 32,
   parameter longint unsigned BASE_ADDR = 0,
   parameter int              CH_STRIDE = 16,
   parameter int              HOLD      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NCH-1:0]        cfg_enable,
   input  logic [NCH*DATA_W-1:0] cfg_period,
   input  logic [NCH*DATA_W-1:0] cfg_duty,
   input  logic [DATA_W-1:0]     rd_data,
   output logic [ADDR_W-1:0]     adr,
   output logic                  cs,
   output logic                  wr,
   output logic                  rd,
   output logic [DATA_W-1:0]     d_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
   localparam logic [HC_W-1:0] LAST_HC = HC_W'(HOLD - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
`ifdef PWM_CFG_READBACK_EN
   localparam logic [2:0] S_READ  = 3'd2;
`endif
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]            state;
   logic [CH_W-1:0]       ch_idx;
   logic [1:0]            reg_idx;   // 0 = duty, 1 = period, 2 = enable
   logic [HC_W-1:0]       hold_cnt;
   logic [NCH-1:0]        snap_enable;
   logic [NCH*DATA_W-1:0] snap_period;
   logic [NCH*DATA_W-1:0] snap_duty;

   // Target of the next access to be loaded into adr/d_in. From IDLE the
   // snapshot is being captured on the same edge, so the first access is
   // computed straight from the cfg inputs.
   logic [CH_W-1:0]       ld_ch;
   logic [1:0]            ld_reg;
   logic [NCH-1:0]        src_enable;
   logic [NCH*DATA_W-1:0] src_period;
   logic [NCH*DATA_W-1:0] src_duty;
   logic [DATA_W-1:0]     ld_per;
   logic [DATA_W-1:0]     ld_duty;
   logic [DATA_W-1:0]     ld_data;
   logic [ADDR_W-1:0]     ld_off;
   logic [ADDR_W-1:0]     ld_adr;
   logic                  last_access;

   always_comb begin
      ld_ch      = '0;
      ld_reg     = 2'd0;
      src_enable = snap_enable;
      src_period = snap_period;
      src_duty   = snap_duty;
      if (state == S_IDLE) begin
         src_enable = cfg_enable;
         src_period = cfg_period;
         src_duty   = cfg_duty;
      end else if (reg_idx == 2'd2) begin
         ld_ch  = ch_idx + 1'b1;
         ld_reg = 2'd0;
      end else begin
         ld_ch  = ch_idx;
         ld_reg = reg_idx + 1'b1;
      end

      ld_per  = src_period[int'(ld_ch)*DATA_W +: DATA_W];
      ld_duty = (src_duty[int'(ld_ch)*DATA_W +: DATA_W] > ld_per) ?
                ld_per : src_duty[int'(ld_ch)*DATA_W +: DATA_W];

      case (ld_reg)
         2'd0: begin
            ld_off  = ADDR_W'(8);
            ld_data = ld_duty;
         end
         2'd1: begin
            ld_off  = ADDR_W'(4);
            ld_data = ld_per;
         end
         default: begin
            // A zero period would leave the channel running with no valid
            // cycle, so it is never enabled.
            ld_off  = '0;
            ld_data = (ld_per == '0) ? '0 : DATA_W'(src_enable[ld_ch]);
         end
      endcase

      ld_adr = ADDR_W'(BASE_ADDR) + ADDR_W'(CH_STRIDE) * ADDR_W'(ld_ch) + ld_off;
   end

   assign last_access = (ch_idx == LAST_CH) && (reg_idx == 2'd2);

   assign cs   = (state == S_WRITE)
`ifdef PWM_CFG_READBACK_EN
              || (state == S_READ)
`endif
              ;
   assign wr   = (state == S_WRITE);
   assign busy = cs || (state == S_GAP);
   assign done = (state == S_DONE);

`ifdef PWM_CFG_READBACK_EN
   logic err_q;
   assign rd  = (state == S_READ);
   assign err = err_q;
`else
   logic unused_rd_data;
   assign unused_rd_data = ^rd_data;
   assign rd  = 1'b0;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ch_idx      <= '0;
         reg_idx     <= 2'd0;
         hold_cnt    <= '0;
         adr         <= '0;
         d_in        <= '0;
         snap_enable <= '0;
         snap_period <= '0;
         snap_duty   <= '0;
`ifdef PWM_CFG_READBACK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  snap_enable <= cfg_enable;
                  snap_period <= cfg_period;
                  snap_duty   <= cfg_duty;
                  ch_idx      <= '0;
                  reg_idx     <= 2'd0;
                  hold_cnt    <= '0;
                  adr         <= ld_adr;
                  d_in        <= ld_data;
`ifdef PWM_CFG_READBACK_EN
                  err_q       <= 1'b0;
`endif
                  state       <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (hold_cnt == LAST_HC) begin
                  hold_cnt <= '0;
`ifdef PWM_CFG_READBACK_EN
                  state    <= S_READ;
`else
                  state    <= S_GAP;
`endif
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
`ifdef PWM_CFG_READBACK_EN
            S_READ: begin
               if (hold_cnt == LAST_HC) begin
                  // d_in still holds the value just written.
                  if (rd_data != d_in) err_q <= 1'b1;
                  hold_cnt <= '0;
                  state    <= S_GAP;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
`endif
            S_GAP: begin
               if (last_access) begin
                  state <= S_DONE;
               end else begin
                  ch_idx  <= ld_ch;
                  reg_idx <= ld_reg;
                  adr     <= ld_adr;
                  d_in    <= ld_data;
                  state   <= S_WRITE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb/tb_pwm_cfg_sequencer.sv - scoreboard testbench for pwm_cfg_sequencer
module tb_pwm_cfg_sequencer;

   localparam int NCH  = 2;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int HOLD = 4;
`ifdef PWM_CFG_READBACK_EN
   localparam int CSLEN = 2 * HOLD;
`else
   localparam int CSLEN = HOLD;
`endif
   localparam int SEQ_LEN = 3 * NCH * (CSLEN + 1);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [NCH-1:0]      cfg_enable = '0;
   logic [NCH*DW-1:0]   cfg_period = '0;
   logic [NCH*DW-1:0]   cfg_duty = '0;
   logic [DW-1:0]       rd_data;
   logic [AW-1:0]       adr;
   logic                cs, wr, rd, busy, done, err;
   logic [DW-1:0]       d_in;
   logic                bad_rb = 1'b0;

   pwm_cfg_sequencer #(
      .NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .CH_STRIDE(16), .HOLD(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_enable(cfg_enable), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
      .rd_data(rd_data), .adr(adr), .cs(cs), .wr(wr), .rd(rd), .d_in(d_in),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Bus model: echoes the written value, except ch1 period when bad_rb is set.
   always_comb rd_data = (bad_rb && adr == 32'd20) ? '0 : d_in;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } acc_t;
   acc_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   bit rd_seen = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_expected(input logic [NCH-1:0] en, input logic [NCH*DW-1:0] per,
                                input logic [NCH*DW-1:0] duty);
      for (int ch = 0; ch < NCH; ch++) begin
         logic [31:0] p, d, base;
         p    = per[ch*DW +: DW];
         d    = duty[ch*DW +: DW];
         base = 32'(ch * 16);
         exp_q.push_back('{a: base + 32'd8, d: (d > p) ? p : d});
         exp_q.push_back('{a: base + 32'd4, d: p});
         exp_q.push_back('{a: base, d: (p == 0) ? 32'd0 : {31'd0, en[ch]}});
      end
   endtask

   // Bus monitor: pops the scoreboard on each write, checks strobe width and gap.
   int  run_len = 0, gap_len = 0;
   bit  prev_cs = 0, prev_wr = 0, in_seq = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_cs = 0; prev_wr = 0; run_len = 0; gap_len = 0; in_seq = 0;
      end else begin
         acc_t e;
         if (done) done_cnt++;
         if (rd) rd_seen = 1;
         if (cs && !prev_cs) begin
            if (in_seq) chk("gap_len", gap_len, 1);
            run_len = 0;
         end
         if (wr && !prev_wr) begin
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("wr_adr", adr, e.a);
               chk("wr_data", d_in, e.d);
            end
         end
         if (cs) run_len++;
         if (!cs && prev_cs) begin
            chk("cs_len", run_len, CSLEN);
            in_seq  = busy;
            gap_len = 0;
         end
         if (!cs) gap_len++;
         if (!busy) in_seq = 0;
         prev_cs = cs;
         prev_wr = wr;
      end
   end

   task automatic run_seq(input string name, input logic [NCH-1:0] en,
                          input logic [NCH*DW-1:0] per, input logic [NCH*DW-1:0] duty,
                          input bit busy_test, input bit exp_err);
      int n, d0;
      cfg_enable = en; cfg_period = per; cfg_duty = duty;
      push_expected(en, per, duty);
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk({name, "_busy"}, busy, 1);
      chk({name, "_err_clr"}, err, 0);
      n = 0;
      while (!done && n < SEQ_LEN + 20) begin
         @(negedge clk);
         n++;
         if (busy_test && n == 5)  cfg_duty = ~duty;
         if (busy_test && n == 10) start = 1'b1;
         if (busy_test && n == 11) start = 1'b0;
      end
      chk({name, "_done_lat"}, n, SEQ_LEN);
      chk({name, "_busy_at_done"}, busy, 0);
      if (busy_test) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      chk({name, "_done_count"}, done_cnt - d0, 1);
      chk({name, "_queue_left"}, exp_q.size(), 0);
      chk({name, "_idle_after"}, busy, 0);
      chk({name, "_err"}, err, exp_err);
      cfg_duty = duty;
   endtask

   localparam logic [NCH*DW-1:0] BASIC_PER  = {32'd5000, 32'd2000000};
   localparam logic [NCH*DW-1:0] BASIC_DUTY = {32'd1000, 32'd230000};

   initial begin
      int act, d0;
      repeat (3) @(negedge clk);
      chk("rst_adr", adr, 0);
      chk("rst_d_in", d_in, 0);
      chk("rst_cs", cs, 0);
      chk("rst_wr", wr, 0);
      chk("rst_rd", rd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk); #2 rst = 1'b1;
      #1 chk("idle_rst_busy", busy, 0);
      chk("idle_rst_cs", cs, 0);
      @(negedge clk) rst = 1'b0;
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (cs | wr | rd | busy | done) act++;
      end
      chk("idle_activity", act, 0);

      run_seq("basic", 2'b11, BASIC_PER, BASIC_DUTY, 1'b0, 1'b0);
      run_seq("sat", 2'b11, {32'd0, 32'd500}, {32'd77, 32'd900}, 1'b0, 1'b0);
      run_seq("busy_snap", 2'b11, BASIC_PER, BASIC_DUTY, 1'b1, 1'b0);
      run_seq("en_off", 2'b01, {32'd100, 32'd100}, {32'd50, 32'd100}, 1'b0, 1'b0);

      // Reset in the middle of the third access.
      cfg_enable = 2'b11; cfg_period = BASIC_PER; cfg_duty = BASIC_DUTY;
      push_expected(2'b11, BASIC_PER, BASIC_DUTY);
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (11) @(negedge clk);
      chk("midrst_cs_before", cs, 1);
      @(posedge clk); #2 rst = 1'b1;
      #1 chk("midrst_cs", cs, 0);
      chk("midrst_wr", wr, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_adr", adr, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (40) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      run_seq("after_rst", 2'b11, BASIC_PER, BASIC_DUTY, 1'b0, 1'b0);

`ifdef PWM_CFG_READBACK_EN
      bad_rb = 1'b1;
      run_seq("rb_bad", 2'b11, BASIC_PER, BASIC_DUTY, 1'b0, 1'b1);
      bad_rb = 1'b0;
      run_seq("rb_good", 2'b11, BASIC_PER, BASIC_DUTY, 1'b0, 1'b0);
`else
      chk("rd_never", rd_seen, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
